mul_issue_ctrl: RTL
===================

Name: mul_issue_ctrl

Overview:
Sequencer between the fixed-point issue stage and the sequential multiplier. It accepts one multiply op (mullw/mulhw/mulhwu, optional Rc/OE), holds operands and signedness stable for the whole operation, and waits out the multiplier. It then captures the registered product and compare fields and presents a single writeback beat: GPR data, CR0 and XER OV/SO. Stalls issue while busy and supports pipeline flush of an in-flight op.

Parameters:
DWIDTH, 32, operand/result word width
TIMEOUT, 64, max cycles in WAIT before error (only with MUL_CTRL_TIMEOUT_EN)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
issue_valid  in  1  op offered
issue_ready  out  1  op accepted when valid&ready
issue_hi  in  1  1=return high word (mulhw[u]), 0=low word (mullw)
issue_uns  in  1  unsigned multiply
issue_rc  in  1  record CR0
issue_oe  in  1  record XER OV/SO (low-word ops only)
issue_a, issue_b  in  DWIDTH  operands
xer_so_in  in  1  current XER.SO
flush  in  1  discard op in flight
mul_en  out  1  start request to multiplier
mul_uns  out  1  signedness to multiplier
mul_a, mul_b  out  DWIDTH  held operands
mul_ready  in  1  multiplier idle, start taken when mul_en&mul_ready
mul_complete  in  1  multiplier completion pulse
mul_res_hi, mul_res_lo  in  DWIDTH  registered product, valid cycle after mul_complete
mul_crf_hi, mul_crf_lo  in  4  registered {lt,gt,eq,ov}, valid cycle after mul_complete
wb_valid  out  1  writeback beat valid
wb_ready  in  1  writeback accepted
wb_data  out  DWIDTH  selected result word
wb_cr_we  out  1  CR0 write enable (= captured rc)
wb_cr  out  4  CR0 {lt,gt,eq,so}
wb_xer_we  out  1  XER write enable
wb_ov, wb_so  out  1  XER OV/SO values
busy  out  1  state != IDLE
error  out  1  sticky timeout flag

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs and held regs 0; issue_ready=0 during reset, 1 in IDLE.
- States: IDLE, START, WAIT, CAPTURE, WB, DRAIN, ERR.
- IDLE: issue_ready=1; on issue_valid, latch a,b,hi,uns,rc,oe -> START.
- START: mul_en=1; mul_ready=1 -> WAIT; else stay (multiplier still in init).
- WAIT: mul_complete -> CAPTURE.
- CAPTURE: mul_res_*/mul_crf_* now valid; latch wb regs -> WB.
- WB: wb_valid=1 until wb_ready; wb_valid&wb_ready -> IDLE. Next op accepted earliest the cycle after.
- mul_a/mul_b/mul_uns held constant from START through CAPTURE (multiplier muxes result on uns at completion).
- Latency: accept edge T; mul_en at T+1; with mul_ready at T+1 and complete at T+1+9, wb_valid from T+12 (minimum 11 cycles).
- Result select: wb_data = hi ? mul_res_hi : mul_res_lo; compare bits from the matching crf.
- ov = ~hi & ~uns & mul_crf_lo.ov; ov is 0 for hi-word and unsigned ops.
- wb_so = xer_so_in (sampled in CAPTURE) | ov.
- wb_cr = {crf.lt, crf.gt, crf.eq, wb_so}; wb_xer_we = oe & ~hi.
- flush: IDLE/WB -> IDLE, beat dropped. START -> IDLE, no start issued. WAIT/CAPTURE -> DRAIN.
- DRAIN: busy=1, issue_ready=0; wait mul_complete, then one cycle, -> IDLE, no writeback.
- flush and issue_valid in the same IDLE cycle: flush wins, nothing latched.
- Reset mid-operation: returns to IDLE. Multiplier shares the reset, so no stale completion.

Optional Feature:
MUL_CTRL_TIMEOUT_EN: counter counts cycles in WAIT/DRAIN.
- Reaching TIMEOUT -> ERR: error=1 (sticky until reset), busy=1, issue_ready=0.
- Without macro: no counter, ERR unreachable, error tied 0.

Test Plan:
- uns=1, hi=0, a=7, b=6, rc=1 -> wb_data=0x0000002A, wb_cr=4'b0100 (gt), wb_cr_we=1, wb_xer_we=0.
- uns=0, hi=1, a=0xFFFFFFFF, b=1, rc=1 -> wb_data=0xFFFFFFFF, wb_cr=4'b1000 (lt).
- uns=0, hi=0, oe=1, rc=1, a=b=0x00010000, xer_so_in=0 -> wb_data=0, wb_ov=1, wb_so=1, wb_cr=4'b0011.
- wb_ready held 0 for 5 cycles after wb_valid -> wb_valid/wb_data stable, issue_ready=0; wb_ready=1 -> IDLE next cycle.
- flush 3 cycles into WAIT -> DRAIN, no wb_valid ever; issue_ready=1 one cycle after mul_complete+1. Next op 2*3 -> 6.
- MUL_CTRL_TIMEOUT_EN, TIMEOUT=16, mul_complete tied 0 -> error=1 after 16 WAIT cycles, stays 1 until reset_n low.

Source files
------------

// File: rtl/mul_issue_ctrl.sv
// rtl/mul_issue_ctrl.sv - issue-to-multiplier sequencer with single-beat writeback
//
// Purpose:
//   Accepts one multiply op (mullw / mulhw / mulhwu, optional Rc / OE) from the
//   fixed-point issue stage, holds operands and signedness stable while the
//   sequential multiplier runs, captures the registered product and compare
//   fields, and presents one writeback beat carrying GPR data, CR0 and XER OV/SO.
//   Issue is stalled while busy; an in-flight op can be flushed.
//
// Optional feature:
//   MUL_CTRL_TIMEOUT_EN - counts cycles spent in WAIT/DRAIN; reaching TIMEOUT
//   enters ERR and sets a sticky error flag. Without it error is tied 0.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   issue_valid / issue_ready    op handshake
//   issue_hi, issue_uns          high-word select, unsigned multiply
//   issue_rc, issue_oe           record CR0, record XER OV/SO
//   issue_a, issue_b             operands
//   xer_so_in                    current XER.SO
//   flush                        discard op in flight
//   mul_en / mul_ready           multiplier start handshake
//   mul_uns, mul_a, mul_b        held signedness and operands
//   mul_complete                 multiplier completion pulse
//   mul_res_hi, mul_res_lo       product words, valid cycle after mul_complete
//   mul_crf_hi, mul_crf_lo       {lt,gt,eq,ov}, valid cycle after mul_complete
//   wb_valid / wb_ready          writeback handshake
//   wb_data                      selected result word
//   wb_cr_we, wb_cr              CR0 write enable and value {lt,gt,eq,so}
//   wb_xer_we, wb_ov, wb_so      XER write enable and OV/SO values
//   busy                         state != IDLE
//   error                        sticky timeout flag

module mul_issue_ctrl #(
    parameter int DWIDTH  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic              issue_hi,
    input  logic              issue_uns,
    input  logic              issue_rc,
    input  logic              issue_oe,
    input  logic [DWIDTH-1:0] issue_a,
    input  logic [DWIDTH-1:0] issue_b,
    input  logic              xer_so_in,
    input  logic              flush,
    output logic              mul_en,
    output logic              mul_uns,
    output logic [DWIDTH-1:0] mul_a,
    output logic [DWIDTH-1:0] mul_b,
    input  logic              mul_ready,
    input  logic              mul_complete,
    input  logic [DWIDTH-1:0] mul_res_hi,
    input  logic [DWIDTH-1:0] mul_res_lo,
    input  logic [3:0]        mul_crf_hi,
    input  logic [3:0]        mul_crf_lo,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DWIDTH-1:0] wb_data,
    output logic              wb_cr_we,
    output logic [3:0]        wb_cr,
    output logic              wb_xer_we,
    output logic              wb_ov,
    output logic              wb_so,
    output logic              busy,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_WB      = 3'd4,
        S_DRAIN   = 3'd5,
        S_ERR     = 3'd6
    } state_t;

    state_t              state_q;
    logic [DWIDTH-1:0]   a_q;
    logic [DWIDTH-1:0]   b_q;
    logic                hi_q;
    logic                uns_q;
    logic                rc_q;
    logic                oe_q;
    logic                mul_en_q;
    logic                issue_ready_q;
    logic                busy_q;
    logic                wb_valid_q;
    logic [DWIDTH-1:0]   wb_data_q;
    logic                wb_cr_we_q;
    logic [3:0]          wb_cr_q;
    logic                wb_xer_we_q;
    logic                wb_ov_q;
    logic                wb_so_q;
    // In DRAIN: the multiplier's completion pulse has already been observed.
    logic                drain_cmpl_q;

`ifdef MUL_CTRL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]    cnt_q;
    logic                error_q;
    logic                timeout_hit;
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
`endif

    // Compare fields follow the selected word. For a low-word op crf_sel is
    // mul_crf_lo, so its ov bit is exactly the low-word overflow; hi-word and
    // unsigned ops never report overflow.
    logic [3:0] crf_sel;
    logic       ov_d;
    logic       so_d;
    assign crf_sel = hi_q ? mul_crf_hi : mul_crf_lo;
    assign ov_d    = ~hi_q & ~uns_q & crf_sel[0];
    assign so_d    = xer_so_in | ov_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            a_q           <= '0;
            b_q           <= '0;
            hi_q          <= 1'b0;
            uns_q         <= 1'b0;
            rc_q          <= 1'b0;
            oe_q          <= 1'b0;
            mul_en_q      <= 1'b0;
            issue_ready_q <= 1'b0;
            busy_q        <= 1'b0;
            wb_valid_q    <= 1'b0;
            wb_data_q     <= '0;
            wb_cr_we_q    <= 1'b0;
            wb_cr_q       <= 4'b0;
            wb_xer_we_q   <= 1'b0;
            wb_ov_q       <= 1'b0;
            wb_so_q       <= 1'b0;
            drain_cmpl_q  <= 1'b0;
`ifdef MUL_CTRL_TIMEOUT_EN
            cnt_q         <= '0;
            error_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    // issue_ready comes up on the first clock after reset.
                    issue_ready_q <= 1'b1;
                    if (issue_ready_q && issue_valid && !flush) begin
                        a_q           <= issue_a;
                        b_q           <= issue_b;
                        hi_q          <= issue_hi;
                        uns_q         <= issue_uns;
                        rc_q          <= issue_rc;
                        oe_q          <= issue_oe;
                        mul_en_q      <= 1'b1;
                        issue_ready_q <= 1'b0;
                        busy_q        <= 1'b1;
                        state_q       <= S_START;
                    end
                end

                S_START: begin
                    if (flush) begin
                        mul_en_q      <= 1'b0;
                        issue_ready_q <= 1'b1;
                        busy_q        <= 1'b0;
                        state_q       <= S_IDLE;
                    end else if (mul_ready) begin
                        mul_en_q <= 1'b0;
                        state_q  <= S_WAIT;
`ifdef MUL_CTRL_TIMEOUT_EN
                        cnt_q    <= '0;
`endif
                    end
                end

                S_WAIT: begin
                    if (flush) begin
                        // A completion in the flush cycle is already consumed.
                        drain_cmpl_q <= mul_complete;
                        state_q      <= S_DRAIN;
`ifdef MUL_CTRL_TIMEOUT_EN
                        cnt_q        <= cnt_q + 1'b1;
`endif
                    end else if (mul_complete) begin
                        state_q <= S_CAPTURE;
`ifdef MUL_CTRL_TIMEOUT_EN
                    end else if (timeout_hit) begin
                        error_q <= 1'b1;
                        state_q <= S_ERR;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
`endif
                    end
                end

                S_CAPTURE: begin
                    if (flush) begin
                        // Completion was seen on entry to CAPTURE, so DRAIN
                        // only needs its trailing cycle.
                        drain_cmpl_q <= 1'b1;
                        state_q      <= S_DRAIN;
                    end else begin
                        wb_data_q   <= hi_q ? mul_res_hi : mul_res_lo;
                        wb_cr_q     <= {crf_sel[3:1], so_d};
                        wb_cr_we_q  <= rc_q;
                        wb_xer_we_q <= oe_q & ~hi_q;
                        wb_ov_q     <= ov_d;
                        wb_so_q     <= so_d;
                        wb_valid_q  <= 1'b1;
                        state_q     <= S_WB;
                    end
                end

                S_WB: begin
                    if (flush || wb_ready) begin
                        wb_valid_q    <= 1'b0;
                        issue_ready_q <= 1'b1;
                        busy_q        <= 1'b0;
                        state_q       <= S_IDLE;
                    end
                end

                S_DRAIN: begin
                    if (drain_cmpl_q) begin
                        drain_cmpl_q  <= 1'b0;
                        issue_ready_q <= 1'b1;
                        busy_q        <= 1'b0;
                        state_q       <= S_IDLE;
                    end else if (mul_complete) begin
                        drain_cmpl_q <= 1'b1;
`ifdef MUL_CTRL_TIMEOUT_EN
                    end else if (timeout_hit) begin
                        error_q <= 1'b1;
                        state_q <= S_ERR;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
`endif
                    end
                end

                S_ERR: begin
                    // Terminal until reset.
                    state_q <= S_ERR;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // The start request is masked by flush so a flush in START can never
    // hand an op to the multiplier in the same cycle.
    assign mul_en      = mul_en_q & ~flush;
    assign mul_uns     = uns_q;
    assign mul_a       = a_q;
    assign mul_b       = b_q;
    assign issue_ready = issue_ready_q;
    assign busy        = busy_q;
    assign wb_valid    = wb_valid_q;
    assign wb_data     = wb_data_q;
    assign wb_cr_we    = wb_cr_we_q;
    assign wb_cr       = wb_cr_q;
    assign wb_xer_we   = wb_xer_we_q;
    assign wb_ov       = wb_ov_q;
    assign wb_so       = wb_so_q;

`ifdef MUL_CTRL_TIMEOUT_EN
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

endmodule
